// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester valid/ready arbiter in front of the shared combinational ALU
//
// Purpose: accepts one ALU operation at a time from requester 0 or 1, registers
// its operands, drives the external ALU for one cycle, and returns a registered
// result, flags and error bit to the requester that issued it.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   req_valid_N / req_ready_N         request handshake, requester N
//   req_op_N, req_a_N, req_b_N        funct code and operands, requester N
//   resp_valid_N / resp_ready_N       response handshake, requester N
//   resp_result, resp_flags, resp_err shared registered response payload
//   busy                              transaction in flight (EXEC or RESP)
//   alu_reg_one, alu_reg_two, alu_op  registered drives into the ALU
//   alu_result, alu_*_f               ALU result and flags

module alu_arbiter #(
  parameter int DATA_W     = 32,
  parameter int PRIO_FIXED = 0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic [5:0]        req_op_0,
  input  logic [DATA_W-1:0] req_a_0,
  input  logic [DATA_W-1:0] req_b_0,

  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic [5:0]        req_op_1,
  input  logic [DATA_W-1:0] req_a_1,
  input  logic [DATA_W-1:0] req_b_1,

  output logic              resp_valid_0,
  input  logic              resp_ready_0,
  output logic              resp_valid_1,
  input  logic              resp_ready_1,
  output logic [DATA_W-1:0] resp_result,
  output logic [3:0]        resp_flags,
  output logic              resp_err,

  output logic              busy,

  output logic [DATA_W-1:0] alu_reg_one,
  output logic [DATA_W-1:0] alu_reg_two,
  output logic [5:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero_f,
  input  logic              alu_negative_f,
  input  logic              alu_overflow_f,
  input  logic              alu_carry_f
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant;  // requester granted most recently
  logic              owner;       // requester that owns the in-flight op
  logic [5:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  logic in_idle;
  logic grant_1;
  logic accept;
  logic resp_taken;
  logic op_ok;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      6'd0, 6'd2, 6'd3, 6'd8,
      6'd32, 6'd34, 6'd36, 6'd37,
      6'd38, 6'd39, 6'd42: op_supported = 1'b1;
      default:             op_supported = 1'b0;
    endcase
  endfunction

  // Requester 1 wins when it is alone, or on a tie when round-robin says it
  // is its turn (requester 0 was served last).
  always_comb begin
    in_idle     = rst_n && (state == IDLE);
    grant_1     = req_valid_1 &&
                  (!req_valid_0 || ((PRIO_FIXED == 0) && !last_grant));
    req_ready_0 = in_idle && req_valid_0 && !grant_1;
    req_ready_1 = in_idle && grant_1;
    accept      = (req_valid_0 && req_ready_0) || (req_valid_1 && req_ready_1);
    resp_taken  = owner ? resp_ready_1 : resp_ready_0;
    op_ok       = op_supported(op_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      resp_result <= '0;
      resp_flags  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= grant_1;
            last_grant <= grant_1;
            op_q       <= grant_1 ? req_op_1 : req_op_0;
            a_q        <= grant_1 ? req_a_1  : req_a_0;
            b_q        <= grant_1 ? req_b_1  : req_b_0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // Unsupported codes still spend the EXEC cycle so latency is uniform.
          if (op_ok) begin
            resp_result <= alu_result;
            resp_flags  <= {alu_zero_f, alu_negative_f, alu_overflow_f, alu_carry_f};
            resp_err    <= 1'b0;
          end else begin
            resp_result <= '0;
            resp_flags  <= '0;
            resp_err    <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (resp_taken) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid_0 = (state == RESP) && !owner;
  assign resp_valid_1 = (state == RESP) && owner;
  assign busy         = (state != IDLE);
  assign alu_reg_one  = a_q;
  assign alu_reg_two  = b_q;
  assign alu_op       = op_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single ALU of the MIPS datapath between two requesters (e.g. main pipeline issue and a debug/self-test port) using a valid/ready handshake on both request and response sides. Arbitrates round-robin (or fixed priority), registers operands, drives the ALU, and returns a registered result plus the four ALU flags to the winning requester. Sits between the requesters and the combinational ALU; the ALU itself is unchanged.

## Interface
- DATA_W, 32, operand/result width; must equal ALU width
- PRIO_FIXED, 0, 0 = round-robin; 1 = requester 0 always wins when both request

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- req_valid_0 / req_valid_1  in  1  request present
- req_ready_0 / req_ready_1  out  1  request accepted this cycle
- req_op_0 / req_op_1  in  6  ALU funct code
- req_a_0 / req_a_1  in  DATA_W  operand one
- req_b_0 / req_b_1  in  DATA_W  operand two / shift amount
- resp_valid_0 / resp_valid_1  out  1  response available
- resp_ready_0 / resp_ready_1  in  1  requester takes response
- resp_result  out  DATA_W  registered ALU result (shared by both requesters)
- resp_flags  out  4  {zero, negative, overflow, carry}
- resp_err  out  1  unsupported op code
- busy  out  1  state != IDLE
- alu_reg_one, alu_reg_two  out  DATA_W  ALU operand drives
- alu_op  out  6  ALU op drive
- alu_result  in  DATA_W  ALU result
- alu_zero_f, alu_negative_f, alu_overflow_f, alu_carry_f  in  1  ALU flags

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid, pick winner; req_ready asserted (combinational) only for the winner, only in IDLE. On valid&&ready: latch op/a/b and owner ID, go EXEC.
- Arbitration: one requester valid -> it wins. Both valid -> PRIO_FIXED=1: requester 0; else the requester not granted last. Last-grant pointer updates on acceptance; resets to "1 granted last", so requester 0 wins the first tie.
- EXEC: alu_* driven from latched registers; at the end of the cycle capture alu_result and flags into resp registers; go RESP.
- Supported ops: 0 sll, 2 srl, 3 sra, 8 jr, 32 add, 34 sub, 36 and, 37 or, 38 xor, 39 nor, 42 slt. Any other op: resp_result=0, resp_flags=0, resp_err=1; still passes through EXEC (same latency).
- RESP: resp_valid_<owner>=1, other resp_valid=0; resp_result/flags/err held stable until resp_ready_<owner>; on handshake go IDLE.
- alu_* outputs always reflect latched registers (no combinational path from req_* to ALU).
- Non-owner resp_ready ignored. Request inputs of the non-winner ignored; it retries by holding valid.
- Reset: all state cleared; any in-flight transaction is dropped without a response.

## Timing
- Reset values: req_ready_*=0 during reset, resp_valid_*=0, resp_result=0, resp_flags=0, resp_err=0, busy=0, alu_reg_one=alu_reg_two=0, alu_op=0, state IDLE.
- Acceptance in cycle C -> EXEC in C+1 -> resp_valid high in C+2.
- Response handshake in cycle R -> IDLE in R+1; next acceptance earliest R+1. Minimum 3 cycles per operation.
- resp_ready held high: response lasts exactly one cycle. Back-pressure: stays in RESP indefinitely, outputs stable.
- busy high in EXEC and RESP.
- Request arriving during EXEC/RESP: req_ready=0 until IDLE.

## Test plan
- Single add: req_0 op=32, a=5, b=7 -> req_ready_0 in cycle C, resp_valid_0 in C+2, resp_result=12, flags=0000, resp_err=0.
- Tie round-robin: both valid continuously, resp_ready held high -> grants 0,1,0,1; with PRIO_FIXED=1 -> always 0, requester 1 starved.
- Flags/sub: req_1 op=34, a=3, b=3 -> result=0, zero=1; a=0x7FFFFFFF, b=0xFFFFFFFF (op=34) -> overflow=1, result 0x80000000, negative=1.
- Back-pressure: op=0, a=1, b=4, resp_ready_0 low 5 cycles -> resp_valid_0 high 5+ cycles, result=16 stable, busy=1, req_1 not accepted.
- Illegal op 63 -> resp_err=1, result=0, flags=0, latency unchanged; next op 42 (a=2,b=9) -> result=1, resp_err=0.
- Reset in EXEC: rst_n low one cycle -> no resp_valid, all outputs at reset values, next tie grants requester 0.
